id_hazard_ctrl: RTL and testbench

//  Parametrised ID-stage operand/hazard controller; successor to the fixed 2-port, 2-stage decoder forwarding logic.

---
 rtl/id_hazard_ctrl_pkg.sv | 20 ++
 rtl/id_hazard_ctrl_if.sv | 48 ++++
 rtl/id_hazard_ctrl_fwd_mux.sv | 40 ++++
 rtl/id_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_id_hazard_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared constants and helpers for the ID-stage operand/hazard controller.
// The optional stall performance counter is enabled by defining AZ_HAZARD_PERF_EN.
package id_hazard_ctrl_pkg;

    localparam int unsigned REG_NUM_DEF   = 32;
    localparam int unsigned REG_AW_DEF    = 5;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned RD_PORTS_DEF  = 2;
    localparam int unsigned FWD_DEPTH_DEF = 2;
    localparam int unsigned LD_LAT_DEF    = 2;
    localparam int unsigned SB_CNT_W      = 3;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    // Low bit of element idx inside a flat bus of w-bit elements.
    function automatic int unsigned slice_lo(int unsigned idx, int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Issue, forwarding and ID/EX slot signals of the hazard controller.
// master = decoder/pipeline side, slave = the controller itself.
interface id_hazard_ctrl_if
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RD_PORTS  = RD_PORTS_DEF,
    parameter int unsigned FWD_DEPTH = FWD_DEPTH_DEF
) ();

    logic                          flush;
    logic                          issue_valid;
    logic                          issue_ready;
    logic [RD_PORTS*REG_AW-1:0]    src_addr;
    logic [RD_PORTS-1:0]           src_used;
    logic [REG_AW-1:0]             dst_addr;
    logic                          dst_we;
    logic                          is_load;
    logic [RD_PORTS*DATA_W-1:0]    rf_rd_data;
    logic [FWD_DEPTH-1:0]          fwd_valid;
    logic [FWD_DEPTH*REG_AW-1:0]   fwd_addr;
    logic [FWD_DEPTH-1:0]          fwd_data_ok;
    logic [FWD_DEPTH*DATA_W-1:0]   fwd_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [RD_PORTS*DATA_W-1:0]    out_src_data;
    logic [REG_AW-1:0]             out_dst_addr;
    logic                          out_dst_we;
    logic                          out_is_load;
    logic                          stall;
    logic [31:0]                   stall_cycles;

    modport master (
        output flush, issue_valid, src_addr, src_used, dst_addr, dst_we, is_load,
               rf_rd_data, fwd_valid, fwd_addr, fwd_data_ok, fwd_data, out_ready,
        input  issue_ready, out_valid, out_src_data, out_dst_addr, out_dst_we,
               out_is_load, stall, stall_cycles
    );

    modport slave (
        input  flush, issue_valid, src_addr, src_used, dst_addr, dst_we, is_load,
               rf_rd_data, fwd_valid, fwd_addr, fwd_data_ok, fwd_data, out_ready,
        output issue_ready, out_valid, out_src_data, out_dst_addr, out_dst_we,
               out_is_load, stall, stall_cycles
    );

endinterface

// File: rtl/id_hazard_ctrl_fwd_mux.sv
// Per-read-port operand selector: youngest matching forwarding stage wins over the
// register file; r0 always reads zero and never reports a match.
module id_hazard_ctrl_fwd_mux
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned FWD_DEPTH = FWD_DEPTH_DEF
) (
    input  logic [REG_AW-1:0]           src,
    input  logic [DATA_W-1:0]           rf_data,
    input  logic [FWD_DEPTH-1:0]        fwd_valid,
    input  logic [FWD_DEPTH*REG_AW-1:0] fwd_addr,
    input  logic [FWD_DEPTH-1:0]        fwd_data_ok,
    input  logic [FWD_DEPTH*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]           data,
    output logic                        hit,
    output logic                        pending
);

    always_comb begin
        data    = rf_data;
        hit     = 1'b0;
        pending = 1'b0;
        // Walk oldest to youngest so the youngest match is the last one written.
        for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
            if (fwd_valid[s] && (fwd_addr[s*REG_AW +: REG_AW] == src)) begin
                data    = fwd_data[s*DATA_W +: DATA_W];
                hit     = 1'b1;
                pending = !fwd_data_ok[s];
            end
        end
        if (src == '0) begin
            data    = '0;
            hit     = 1'b0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage operand resolution, load-use scoreboard and ID/EX slot.
// Define AZ_HAZARD_PERF_EN to build the saturating stall_cycles counter.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM   = REG_NUM_DEF,
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RD_PORTS  = RD_PORTS_DEF,
    parameter int unsigned FWD_DEPTH = FWD_DEPTH_DEF,
    parameter int unsigned LD_LAT    = LD_LAT_DEF
) (
    input logic            clk,
    input logic            reset,
    id_hazard_ctrl_if.slave bus
);

    localparam sb_cnt_t LdLat = sb_cnt_t'(LD_LAT);

    sb_cnt_t                    sb_cnt [REG_NUM];
    logic [RD_PORTS-1:0]        hazard;
    logic [RD_PORTS*DATA_W-1:0] operand;
    logic                       any_hazard;
    logic                       issue_ready;
    logic                       accept;
    logic                       sb_set;

    logic                       slot_valid;
    logic [RD_PORTS*DATA_W-1:0] slot_data;
    logic [REG_AW-1:0]          slot_dst;
    logic                       slot_we;
    logic                       slot_load;

    genvar p;
    for (p = 0; p < RD_PORTS; p++) begin : g_port
        logic [REG_AW-1:0] src;
        logic [DATA_W-1:0] data;
        logic              hit;
        logic              pending;

        assign src = bus.src_addr[slice_lo(p, REG_AW) +: REG_AW];

        id_hazard_ctrl_fwd_mux #(
            .REG_AW    (REG_AW),
            .DATA_W    (DATA_W),
            .FWD_DEPTH (FWD_DEPTH)
        ) u_fwd_mux (
            .src         (src),
            .rf_data     (bus.rf_rd_data[slice_lo(p, DATA_W) +: DATA_W]),
            .fwd_valid   (bus.fwd_valid),
            .fwd_addr    (bus.fwd_addr),
            .fwd_data_ok (bus.fwd_data_ok),
            .fwd_data    (bus.fwd_data),
            .data        (data),
            .hit         (hit),
            .pending     (pending)
        );

        assign operand[slice_lo(p, DATA_W) +: DATA_W] = data;
        // A forwarding hit overrides the scoreboard: the stage already owns the value.
        assign hazard[p] = bus.src_used[p] && (src != '0) &&
                           (pending || (!hit && (sb_cnt[src] != '0)));
    end

    assign any_hazard  = |hazard;
    assign issue_ready = !bus.flush && !any_hazard && (!slot_valid || bus.out_ready);
    assign accept      = bus.issue_valid && issue_ready;
    assign sb_set      = accept && bus.is_load && bus.dst_we && (bus.dst_addr != '0);

    assign bus.issue_ready = issue_ready;
    assign bus.stall       = bus.issue_valid && !issue_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                sb_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                if (sb_set && (bus.dst_addr == REG_AW'(r))) begin
                    sb_cnt[r] <= LdLat;
                end else if (sb_cnt[r] != '0) begin
                    sb_cnt[r] <= sb_cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            slot_dst   <= '0;
            slot_we    <= 1'b0;
            slot_load  <= 1'b0;
        end else if (bus.flush) begin
            slot_valid <= 1'b0;
        end else if (accept) begin
            slot_valid <= 1'b1;
            slot_data  <= operand;
            slot_dst   <= bus.dst_addr;
            slot_we    <= bus.dst_we && (bus.dst_addr != '0);
            slot_load  <= bus.is_load;
        end else if (bus.out_ready) begin
            slot_valid <= 1'b0;
        end
    end

    assign bus.out_valid    = slot_valid;
    assign bus.out_src_data = slot_data;
    assign bus.out_dst_addr = slot_dst;
    assign bus.out_dst_we   = slot_we;
    assign bus.out_is_load  = slot_load;

`ifdef AZ_HAZARD_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (bus.stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model of operand selection, scoreboard and slot.
module tb_id_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned NP  = 2;
    localparam int unsigned ND  = 2;
    localparam int unsigned LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.REG_AW(AW), .DATA_W(DW), .RD_PORTS(NP), .FWD_DEPTH(ND)) bus ();

    id_hazard_ctrl #(
        .REG_NUM   (32),
        .REG_AW    (AW),
        .DATA_W    (DW),
        .RD_PORTS  (NP),
        .FWD_DEPTH (ND),
        .LD_LAT    (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle();
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.src_addr    = '0;
        bus.src_used    = '0;
        bus.dst_addr    = '0;
        bus.dst_we      = 1'b0;
        bus.is_load     = 1'b0;
        bus.rf_rd_data  = '0;
        bus.fwd_valid   = '0;
        bus.fwd_addr    = '0;
        bus.fwd_data_ok = '1;
        bus.fwd_data    = '0;
        bus.out_ready   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_instr(input logic [AW-1:0] s0, input logic u0, input logic [AW-1:0] s1,
                             input logic u1, input logic [AW-1:0] d, input logic we,
                             input logic ld);
        bus.issue_valid = 1'b1;
        bus.src_addr    = {s1, s0};
        bus.src_used    = {u1, u0};
        bus.dst_addr    = d;
        bus.dst_we      = we;
        bus.is_load     = ld;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h exp 0", bus.out_valid); else passes++;
        checks++; if (bus.out_src_data !== '0) $display("FAIL reset_src_data got %0h exp 0", bus.out_src_data); else passes++;
        checks++; if (bus.out_dst_addr !== '0) $display("FAIL reset_dst_addr got %0h exp 0", bus.out_dst_addr); else passes++;
        checks++; if (bus.out_dst_we !== 1'b0) $display("FAIL reset_dst_we got %0h exp 0", bus.out_dst_we); else passes++;
        checks++; if (bus.out_is_load !== 1'b0) $display("FAIL reset_is_load got %0h exp 0", bus.out_is_load); else passes++;
        checks++; if (bus.stall_cycles !== 32'd0) $display("FAIL reset_stall_cycles got %0h exp 0", bus.stall_cycles); else passes++;
        set_instr(5'd5, 1'b1, 5'd31, 1'b1, 5'd1, 1'b1, 1'b0);
        #1;
        checks++; if (bus.issue_ready !== 1'b1) $display("FAIL reset_sb_clear_ready got %0h exp 1", bus.issue_ready); else passes++;
        idle();
    endtask

    task automatic test_fwd_priority();
        do_reset();
        bus.fwd_valid   = 2'b11;
        bus.fwd_addr    = {5'd3, 5'd3};
        bus.fwd_data_ok = 2'b11;
        bus.fwd_data    = {32'h22, 32'h11};
        bus.rf_rd_data  = {32'hABCD, 32'hDEAD};
        set_instr(5'd3, 1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (bus.issue_ready !== 1'b1) $display("FAIL fwd_ready got %0h exp 1", bus.issue_ready); else passes++;
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL fwd_out_valid got %0h exp 1", bus.out_valid); else passes++;
        checks++; if (bus.out_src_data[31:0] !== 32'h11) $display("FAIL fwd_port0 got %0h exp 11", bus.out_src_data[31:0]); else passes++;
        checks++; if (bus.out_src_data[63:32] !== 32'hABCD) $display("FAIL fwd_port1_rf got %0h exp abcd", bus.out_src_data[63:32]); else passes++;
        checks++; if (bus.out_dst_addr !== 5'd4 || bus.out_dst_we !== 1'b1) $display("FAIL fwd_dst got %0h/%0h exp 4/1", bus.out_dst_addr, bus.out_dst_we); else passes++;
        tick();
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL fwd_drain got %0h exp 0", bus.out_valid); else passes++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        checks++; if (bus.issue_ready !== 1'b1) $display("FAIL ld_issue_ready got %0h exp 1", bus.issue_ready); else passes++;
        tick();
        set_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        bus.rf_rd_data = {32'h0, 32'h55};
        #1;
        checks++; if (bus.out_is_load !== 1'b1) $display("FAIL ld_out_is_load got %0h exp 1", bus.out_is_load); else passes++;
        checks++; if (bus.stall !== 1'b1) $display("FAIL ld_stall1 got %0h exp 1", bus.stall); else passes++;
        tick();
        #1;
        checks++; if (bus.stall !== 1'b1) $display("FAIL ld_stall2 got %0h exp 1", bus.stall); else passes++;
        tick();
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.issue_ready !== 1'b1) $display("FAIL ld_release got stall=%0h ready=%0h exp 0/1", bus.stall, bus.issue_ready); else passes++;
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_src_data[31:0] !== 32'h55) $display("FAIL ld_use_data got %0h/%0h exp 1/55", bus.out_valid, bus.out_src_data[31:0]); else passes++;
    endtask

    task automatic test_fwd_pending();
        do_reset();
        bus.fwd_valid   = 2'b11;
        bus.fwd_addr    = {5'd7, 5'd7};
        bus.fwd_data_ok = 2'b10;
        bus.fwd_data    = {32'h99, 32'h77};
        set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.issue_ready !== 1'b0) $display("FAIL pend_stall got %0h/%0h exp 1/0", bus.stall, bus.issue_ready); else passes++;
        tick();
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL pend_no_accept got %0h exp 0", bus.out_valid); else passes++;
        bus.fwd_data_ok = 2'b11;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) $display("FAIL pend_ok_ready got %0h exp 1", bus.issue_ready); else passes++;
        tick();
        idle();
        #1;
        checks++; if (bus.out_src_data[31:0] !== 32'h77) $display("FAIL pend_data got %0h exp 77", bus.out_src_data[31:0]); else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready  = 1'b0;
        bus.rf_rd_data = {32'h0, 32'hA1};
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        bus.rf_rd_data = {32'h0, 32'hB2};
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.issue_ready !== 1'b0) $display("FAIL bp_ready_%0d got %0h exp 0", i, bus.issue_ready); else passes++;
            checks++; if (bus.out_src_data[31:0] !== 32'hA1 || bus.out_dst_addr !== 5'd2) $display("FAIL bp_hold_%0d got %0h/%0h exp a1/2", i, bus.out_src_data[31:0], bus.out_dst_addr); else passes++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) $display("FAIL bp_release got %0h exp 1", bus.issue_ready); else passes++;
        tick();
        idle();
        #1;
        checks++; if (bus.out_src_data[31:0] !== 32'hB2 || bus.out_dst_addr !== 5'd3) $display("FAIL bp_next got %0h/%0h exp b2/3", bus.out_src_data[31:0], bus.out_dst_addr); else passes++;
    endtask

    task automatic test_r0_and_flush();
        do_reset();
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        #1;
        checks++; if (bus.out_dst_we !== 1'b0 || bus.out_is_load !== 1'b1) $display("FAIL r0_dst_we got %0h/%0h exp 0/1", bus.out_dst_we, bus.out_is_load); else passes++;
        bus.fwd_valid   = 2'b01;
        bus.fwd_addr    = '0;
        bus.fwd_data_ok = 2'b10;
        bus.fwd_data    = {32'h1234, 32'h5678};
        bus.rf_rd_data  = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL r0_no_stall got %0h exp 0", bus.stall); else passes++;
        tick();
        idle();
        #1;
        checks++; if (bus.out_src_data !== '0) $display("FAIL r0_operand got %0h exp 0", bus.out_src_data); else passes++;
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        set_instr(5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.issue_ready !== 1'b0 || bus.stall !== 1'b1) $display("FAIL flush_stall got %0h/%0h exp 0/1", bus.issue_ready, bus.stall); else passes++;
        tick();
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_clears_slot got %0h exp 0", bus.out_valid); else passes++;
        checks++; if (bus.stall !== 1'b1) $display("FAIL flush_keeps_sb got %0h exp 1", bus.stall); else passes++;
        tick();
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL flush_sb_expire got %0h exp 0", bus.stall); else passes++;
        idle();
    endtask

    task automatic test_perf_reset();
        logic [31:0] exp_cnt;
`ifdef AZ_HAZARD_PERF_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        bus.out_ready = 1'b0;
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #1;
        checks++; if (bus.stall_cycles !== exp_cnt) $display("FAIL perf_count got %0d exp %0d", bus.stall_cycles, exp_cnt); else passes++;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL perf_slot_held got %0h exp 1", bus.out_valid); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.stall_cycles !== 32'd0) $display("FAIL perf_mid_reset got %0h/%0d exp 0/0", bus.out_valid, bus.stall_cycles); else passes++;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) $display("FAIL perf_post_reset_ready got %0h exp 1", bus.issue_ready); else passes++;
        idle();
    endtask

    task automatic test_random();
        int              sb [32];
        logic            mv;
        logic [NP*DW-1:0] md;
        logic [AW-1:0]   mdst;
        logic            mwe;
        logic            mld;
        logic [NP*DW-1:0] nop;
        logic [AW-1:0]   src;
        logic [DW-1:0]   op;
        logic            hz;
        logic            found;
        logic            okv;
        logic            exp_ready;
        logic            acc;
        do_reset();
        foreach (sb[i]) sb[i] = 0;
        mv = 1'b0; md = '0; mdst = '0; mwe = 1'b0; mld = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.flush       = ($urandom_range(9, 0) == 0);
            bus.issue_valid = ($urandom_range(3, 0) != 0);
            bus.out_ready   = ($urandom_range(9, 0) < 7);
            bus.dst_addr    = AW'($urandom_range(7, 0));
            bus.dst_we      = 1'($urandom);
            bus.is_load     = ($urandom_range(4, 0) < 2);
            for (int p = 0; p < NP; p++) begin
                bus.src_addr[p*AW +: AW]   = AW'($urandom_range(7, 0));
                bus.src_used[p]            = 1'($urandom);
                bus.rf_rd_data[p*DW +: DW] = $urandom;
            end
            for (int s = 0; s < ND; s++) begin
                bus.fwd_valid[s]         = ($urandom_range(2, 0) == 0);
                bus.fwd_addr[s*AW +: AW] = AW'($urandom_range(7, 0));
                bus.fwd_data_ok[s]       = ($urandom_range(3, 0) != 0);
                bus.fwd_data[s*DW +: DW] = $urandom;
            end
            #1;
            hz = 1'b0;
            for (int p = 0; p < NP; p++) begin
                src   = bus.src_addr[p*AW +: AW];
                op    = bus.rf_rd_data[p*DW +: DW];
                found = 1'b0;
                okv   = 1'b1;
                for (int s = 0; s < ND; s++) begin
                    if (!found && bus.fwd_valid[s] && bus.fwd_addr[s*AW +: AW] == src) begin
                        found = 1'b1;
                        okv   = bus.fwd_data_ok[s];
                        op    = bus.fwd_data[s*DW +: DW];
                    end
                end
                if (src == '0) op = '0;
                else if (bus.src_used[p] && (found ? !okv : (sb[src] != 0))) hz = 1'b1;
                nop[p*DW +: DW] = op;
            end
            exp_ready = !bus.flush && !hz && (!mv || bus.out_ready);
            acc       = bus.issue_valid && exp_ready;
            checks++; if (bus.issue_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got %0h exp %0h", c, bus.issue_ready, exp_ready); else passes++;
            checks++; if (bus.stall !== (bus.issue_valid && !exp_ready)) $display("FAIL rnd_stall c=%0d got %0h exp %0h", c, bus.stall, bus.issue_valid && !exp_ready); else passes++;
            checks++; if (bus.out_valid !== mv) $display("FAIL rnd_out_valid c=%0d got %0h exp %0h", c, bus.out_valid, mv); else passes++;
            checks++; if (bus.out_src_data !== md) $display("FAIL rnd_src_data c=%0d got %0h exp %0h", c, bus.out_src_data, md); else passes++;
            checks++; if ({bus.out_dst_addr, bus.out_dst_we, bus.out_is_load} !== {mdst, mwe, mld}) $display("FAIL rnd_ctrl c=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", c, bus.out_dst_addr, bus.out_dst_we, bus.out_is_load, mdst, mwe, mld); else passes++;
            foreach (sb[r]) if (sb[r] > 0) sb[r] = sb[r] - 1;
            if (acc && bus.is_load && bus.dst_we && bus.dst_addr != '0) sb[bus.dst_addr] = int'(LAT);
            if (bus.flush) begin
                mv = 1'b0;
            end else if (acc) begin
                mv   = 1'b1;
                md   = nop;
                mdst = bus.dst_addr;
                mwe  = bus.dst_we && (bus.dst_addr != '0);
                mld  = bus.is_load;
            end else if (bus.out_ready) begin
                mv = 1'b0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_fwd_pending();
        test_backpressure();
        test_r0_and_flush();
        test_perf_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
